// File: rtl/spi_register_bank.sv
// Command/register stage behind the SPI transceiver: eight 32-bit registers
// (R0-R6 read/write, R7 read-only ID) with single and auto-incrementing burst access.
module spi_register_bank #(
    parameter logic [31:0] ID_VALUE = 32'h5049_4356,
    parameter logic [31:0] RESET_R0 = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic [7:0]  command,
    input  logic        command_ready,
    input  logic [31:0] word_received,
    input  logic        word_rx_complete,
    output logic [31:0] word_to_output,
    output logic [31:0] control_out,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [7:0]  error_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NUM_RW = 7;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RDINV = 2'b10;
    localparam logic [1:0] OP_BURST = 2'b11;

    localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(7);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SINGLE,
        S_BURST,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   regs_q [NUM_RW];
    logic [DATA_W-1:0]   regs_d [NUM_RW];
    logic [DATA_W-1:0]   word_q, word_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic                do_write;
    logic                err;
    logic [DATA_W-1:0]   rd_word;

    // command[5:3] carries no meaning for this block
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^command[5:3];

    // Next-state: the word is applied against the old op/addr before a same-cycle command
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_cnt_d   = err_cnt_q;
        do_write    = 1'b0;
        err         = 1'b0;
        rd_word     = '0;
        word_d      = '0;

        if (cs) begin
            state_d = S_IDLE;
            op_d    = '0;
            addr_d  = '0;
        end else begin
            if (word_rx_complete) begin
                unique case (state_q)
                    S_IDLE:   err = 1'b1;
                    S_SINGLE: begin
                        do_write = (op_q == OP_WRITE);
                        state_d  = S_DONE;
                    end
                    S_BURST: begin
                        do_write = 1'b1;
                        addr_d   = addr_q + ADDR_W'(1);
                    end
                    S_DONE:   err = 1'b1;
                    default:  state_d = S_IDLE;
                endcase
            end

            if (do_write) begin
                if (addr_q == ID_ADDR) begin
                    err = 1'b1;
                end else begin
                    regs_d[addr_q] = word_received;
                    wr_strobe_d    = 1'b1;
                    wr_addr_d      = addr_q;
                    wr_data_d      = word_received;
                end
            end

            if (command_ready) begin
                if (state_q != S_IDLE) begin
                    err = 1'b1;
                end
                op_d    = command[7:6];
                addr_d  = command[ADDR_W-1:0];
                state_d = (command[7:6] == OP_BURST) ? S_BURST : S_SINGLE;
            end
        end

        if (err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        // Outgoing word tracks the next op/addr and the post-write register contents
        if (addr_d == ID_ADDR) begin
            rd_word = ID_VALUE;
        end else begin
            rd_word = regs_d[addr_d];
        end
        if ((state_d == S_SINGLE) || (state_d == S_BURST)) begin
            word_d = (op_d == OP_RDINV) ? ~rd_word : rd_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            regs_q[0]   <= RESET_R0;
            for (int i = 1; i < NUM_RW; i++) begin
                regs_q[i] <= '0;
            end
            word_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            regs_q      <= regs_d;
            word_q      <= word_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign word_to_output = word_q;
    assign control_out    = regs_q[0];
    assign wr_strobe      = wr_strobe_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign error_count    = err_cnt_q;

endmodule

// File: tb/tb_spi_register_bank.sv
// Self-checking bench for spi_register_bank: expected writes are queued as
// stimulus is driven and popped when the DUT raises wr_strobe.
module tb_spi_register_bank;

    localparam logic [31:0] ID_VALUE = 32'h5049_4356;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs;
    logic [7:0]  command;
    logic        command_ready;
    logic [31:0] word_received;
    logic        word_rx_complete;
    logic [31:0] word_to_output;
    logic [31:0] control_out;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  error_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_err      = 0;
    wr_exp_t exp_wr[$];

    spi_register_bank #(
        .ID_VALUE (ID_VALUE),
        .RESET_R0 (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cs               (cs),
        .command          (command),
        .command_ready    (command_ready),
        .word_received    (word_received),
        .word_rx_complete (word_rx_complete),
        .word_to_output   (word_to_output),
        .control_out      (control_out),
        .wr_strobe        (wr_strobe),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .error_count      (error_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every write pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check_eq("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                wr_exp_t e;
                e = exp_wr.pop_front();
                check_eq("wr_addr", 32'(wr_addr), 32'(e.addr));
                check_eq("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cmd(input logic [7:0] c);
        command       = c;
        command_ready = 1'b1;
        tick();
        command_ready = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        word_received    = w;
        word_rx_complete = 1'b1;
        tick();
        word_rx_complete = 1'b0;
    endtask

    task automatic end_xfer();
        cs = 1'b1;
        tick();
        cs = 1'b0;
        tick();
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        end_xfer();
        pulse_cmd({5'b01000, a});
        exp_wr.push_back('{addr: a, data: d});
        send_word(d);
    endtask

    task automatic read_check(input string tag, input logic [7:0] c, input logic [31:0] exp);
        end_xfer();
        pulse_cmd(c);
        check_eq(tag, word_to_output, exp);
    endtask

    initial begin
        reset_n          = 1'b0;
        cs               = 1'b1;
        command          = '0;
        command_ready    = 1'b0;
        word_received    = '0;
        word_rx_complete = 1'b0;
        tick();
        tick();
        check_eq("rst_wto", word_to_output, 32'h0);
        check_eq("rst_ctrl", control_out, 32'h0);
        check_eq("rst_wrs", 32'(wr_strobe), 32'h0);
        check_eq("rst_err", 32'(error_count), 32'h0);
        reset_n = 1'b1;
        tick();

        // Single write of R0, then plain and inverted readback
        cs = 1'b0;
        tick();
        pulse_cmd(8'h40);
        check_eq("t1_wto_wr", word_to_output, 32'h0);
        exp_wr.push_back('{addr: 3'd0, data: 32'hDEAD_BEEF});
        send_word(32'hDEAD_BEEF);
        check_eq("t1_ctrl", control_out, 32'hDEAD_BEEF);
        check_eq("t1_wto_done", word_to_output, 32'h0);
        read_check("t1_rd_r0", 8'h00, 32'hDEAD_BEEF);
        read_check("t1_rdinv_r0", 8'h80, 32'h2152_4110);
        check_eq("t1_err", 32'(error_count), 32'(exp_err));

        // Burst from R5 wraps through read-only R7 to R0
        write_reg(3'd1, 32'h1111_1111);
        write_reg(3'd6, 32'h6666_6666);
        end_xfer();
        pulse_cmd(8'hC5);
        check_eq("t2_wto_r5", word_to_output, 32'h0);
        exp_wr.push_back('{addr: 3'd5, data: 32'd1});
        send_word(32'd1);
        check_eq("t2_wto_r6", word_to_output, 32'h6666_6666);
        exp_wr.push_back('{addr: 3'd6, data: 32'd2});
        send_word(32'd2);
        check_eq("t2_wto_r7", word_to_output, ID_VALUE);
        send_word(32'd3);
        exp_err++;
        check_eq("t2_wto_r0", word_to_output, 32'hDEAD_BEEF);
        exp_wr.push_back('{addr: 3'd0, data: 32'd4});
        send_word(32'd4);
        check_eq("t2_wto_r1", word_to_output, 32'h1111_1111);
        check_eq("t2_err", 32'(error_count), 32'(exp_err));
        check_eq("t2_ctrl", control_out, 32'd4);
        read_check("t2_rd_r5", 8'h05, 32'd1);
        read_check("t2_rd_r6", 8'h06, 32'd2);

        // ID read, extra word in DONE, inverted ID, write to R7
        read_check("t3_rd_id", 8'h07, ID_VALUE);
        send_word(32'hAAAA_0001);
        check_eq("t3_err_first", 32'(error_count), 32'(exp_err));
        check_eq("t3_wto_done", word_to_output, 32'h0);
        send_word(32'hAAAA_0002);
        exp_err++;
        check_eq("t3_err_done", 32'(error_count), 32'(exp_err));
        read_check("t3_rdinv_id", 8'h87, ~ID_VALUE);
        read_check("t3_wr_r7_wto", 8'h47, ID_VALUE);
        send_word(32'hBAD0_0007);
        exp_err++;
        check_eq("t3_err_r7", 32'(error_count), 32'(exp_err));
        read_check("t3_id_intact", 8'h3F, ID_VALUE);

        // Same-cycle restart: word goes to R0, next word to R1
        end_xfer();
        pulse_cmd(8'h40);
        exp_wr.push_back('{addr: 3'd0, data: 32'hA5A5_5A5A});
        command          = 8'h41;
        command_ready    = 1'b1;
        word_received    = 32'hA5A5_5A5A;
        word_rx_complete = 1'b1;
        tick();
        command_ready    = 1'b0;
        word_rx_complete = 1'b0;
        exp_err++;
        check_eq("t5_ctrl", control_out, 32'hA5A5_5A5A);
        check_eq("t5_err", 32'(error_count), 32'(exp_err));
        check_eq("t5_wto_r1", word_to_output, 32'h1111_1111);
        exp_wr.push_back('{addr: 3'd1, data: 32'h1234_5678});
        send_word(32'h1234_5678);
        read_check("t5_rd_r1", 8'h01, 32'h1234_5678);
        read_check("t5_rd_r0", 8'h00, 32'hA5A5_5A5A);

        // Words in IDLE count as errors; counter saturates
        end_xfer();
        send_word(32'h0);
        exp_err++;
        check_eq("t4_err_idle", 32'(error_count), 32'(exp_err));
        for (int i = 0; i < 300; i++) begin
            send_word(32'(i));
        end
        check_eq("t4_err_sat", 32'(error_count), 32'hFF);
        send_word(32'h0);
        check_eq("t4_err_nowrap", 32'(error_count), 32'hFF);

        // Async reset mid-burst with a word strobe pending
        end_xfer();
        pulse_cmd(8'hC2);
        exp_wr.push_back('{addr: 3'd2, data: 32'h2222_2222});
        send_word(32'h2222_2222);
        tick();
        word_received    = 32'h3333_3333;
        word_rx_complete = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_wto", word_to_output, 32'h0);
        check_eq("t6_ctrl", control_out, 32'h0);
        check_eq("t6_wrs", 32'(wr_strobe), 32'h0);
        check_eq("t6_wra", 32'(wr_addr), 32'h0);
        check_eq("t6_wrd", wr_data, 32'h0);
        check_eq("t6_err", 32'(error_count), 32'h0);
        tick();
        word_rx_complete = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check_eq("t6_post_wrs", 32'(wr_strobe), 32'h0);
        check_eq("t6_post_err", 32'(error_count), 32'h0);
        read_check("t6_rd_r2", 8'h02, 32'h0);

        check_eq("wr_queue_empty", 32'(exp_wr.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
